ifu_fetch_queue: RTL

Instruction fetch front end between external instruction memory and the IF/ID pipeline register. It generates sequential fetch addresses and issues one-outstanding read requests over the `mem_read_out`/`mem_valid_in` handshake. Returned instruction words are buffered with their PC in a small FIFO, which the decode side drains with a valid/ready handshake. Branch redirects flush the queue and discard any in-flight response.

---
 rtl/ifu_fetch_queue.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch_queue.sv
// ---------------------------------------------------------------------------
// ifu_fetch_queue
//
// Instruction fetch front end. It sits between the external instruction
// memory and the IF/ID pipeline register. The block produces sequential fetch
// addresses and keeps at most one read request outstanding. Each returned word
// is stored with its PC in a small FIFO, and the decode stage drains that FIFO.
// A branch redirect flushes the FIFO and discards any response still in
// flight.
//
// Optional feature (compile-time macro IFU_FETCH_QUEUE_BYPASS_EN):
//   When the macro is defined and the queue is empty, a response arriving in
//   WAIT is presented combinationally on the ins_* outputs in the same cycle.
//   If the consumer takes it, it is never written into storage. When the
//   macro is undefined, the ins_* outputs always come from storage.
//
// Parameters
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clock_in          single clock, rising edge
//   reset_in          asynchronous, active-low reset
//   halt_in           blocks issue of new requests (in-flight one completes)
//   redirect_in       flush queue and restart fetch at redirect_addr_in
//   redirect_addr_in  new fetch PC (bits [1:0] ignored)
//   mem_addr_out      registered fetch address
//   mem_read_out      registered request, held until accepted
//   mem_valid_in      response valid; also accepts the pending request
//   mem_data_in       instruction word, valid with mem_valid_in
//   ins_valid_out     head entry valid
//   ins_data_out      head instruction
//   ins_pc_out        head PC
//   ins_ready_in      consumer accepts the head entry
//   queue_count_out   occupied entries
//   fsm_state_out     current FSM state (0 IDLE, 1 WAIT, 2 DISCARD)
//
// Handshakes:
//   Memory side. A request is live while mem_read_out=1. The address is
//   stable until a cycle in which mem_valid_in=1; that cycle both completes
//   the request and delivers mem_data_in.
//   Decode side. An entry transfers on a rising edge when ins_valid_out=1 and
//   ins_ready_in=1. ins_ready_in has no effect while ins_valid_out=0.
//   ins_data_out and ins_pc_out stay stable until the entry transfers or a
//   redirect flushes the queue.
// ---------------------------------------------------------------------------
module ifu_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     halt_in,
  input  logic                     redirect_in,
  input  logic [31:0]              redirect_addr_in,
  output logic [31:0]              mem_addr_out,
  output logic                     mem_read_out,
  input  logic                     mem_valid_in,
  input  logic [31:0]              mem_data_in,
  output logic                     ins_valid_out,
  output logic [31:0]              ins_data_out,
  output logic [31:0]              ins_pc_out,
  input  logic                     ins_ready_in,
  output logic [$clog2(DEPTH):0]   queue_count_out,
  output logic [1:0]               fsm_state_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [31:0]        fetch_pc;
  logic [31:0]        next_pc;
  logic [31:0]        redirect_pc;

  // Each entry is {instr, pc}.
  logic [63:0]        entry_q [DEPTH];
  logic [63:0]        head_entry;

  logic               resp_accept;
  logic               push;
  logic               pop;
  logic               queue_valid;
  logic               can_issue;

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  assign queue_valid = (count != '0);
  assign head_entry  = entry_q[head];
  assign next_pc     = fetch_pc + 32'd4;   // wraps 0xFFFFFFFC -> 0
  assign redirect_pc = redirect_addr_in & 32'hFFFF_FFFC;

  // A response counts only in WAIT. A response that arrives in the same cycle
  // as a redirect belongs to the old path and is dropped.
  assign resp_accept = (state == ST_WAIT) && mem_valid_in && !redirect_in;

  // Storage pops only. A bypassed word never occupies a queue slot.
  assign pop = queue_valid && ins_ready_in && !redirect_in;

`ifdef IFU_FETCH_QUEUE_BYPASS_EN
  logic bypass_hit;
  logic bypass_take;

  assign bypass_hit  = resp_accept && !queue_valid;
  assign bypass_take = bypass_hit && ins_ready_in;
  assign push        = resp_accept && !bypass_take;

  always_comb begin
    ins_valid_out = queue_valid;
    ins_data_out  = queue_valid ? head_entry[63:32] : 32'h0;
    ins_pc_out    = queue_valid ? head_entry[31:0]  : 32'h0;
    if (bypass_hit) begin
      ins_valid_out = 1'b1;
      ins_data_out  = mem_data_in;
      ins_pc_out    = mem_addr_out;
    end
  end
`else
  assign push = resp_accept;

  // When the queue is empty the outputs are forced to zero, so a flush never
  // exposes stale storage contents.
  always_comb begin
    ins_valid_out = queue_valid;
    ins_data_out  = queue_valid ? head_entry[63:32] : 32'h0;
    ins_pc_out    = queue_valid ? head_entry[31:0]  : 32'h0;
  end
`endif

  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // Issue is safe whenever a slot will be free after this edge. Because only
  // one request is ever outstanding, the next response always has room.
  assign can_issue = !halt_in && (count_next < CNT_W'(DEPTH));

  assign queue_count_out = count;
  assign fsm_state_out   = state;

  // ---------------------------------------------------------------------------
  // Queue storage (data only, no reset needed: count gates visibility)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_in) begin
    if (push) begin
      entry_q[tail] <= {mem_data_in, mem_addr_out};
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, count, fetch PC
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= RESET_PC;
    end else if (redirect_in) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= redirect_pc;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count_next;
      if (resp_accept) begin
        fetch_pc <= next_pc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM. mem_addr_out and mem_read_out are registered here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state        <= ST_IDLE;
      mem_read_out <= 1'b0;
      mem_addr_out <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          // A late response seen here belongs to nobody and is ignored.
          if (!redirect_in && can_issue) begin
            state        <= ST_WAIT;
            mem_read_out <= 1'b1;
            mem_addr_out <= fetch_pc;
          end
        end

        ST_WAIT: begin
          if (redirect_in) begin
            if (mem_valid_in) begin
              // The old request finished in this same cycle. Nothing is left
              // to discard.
              state        <= ST_IDLE;
              mem_read_out <= 1'b0;
            end else begin
              // The old request must still complete on the bus. Keep it up
              // and throw the answer away.
              state <= ST_DISCARD;
            end
          end else if (mem_valid_in) begin
            if (can_issue) begin
              mem_addr_out <= next_pc;   // back-to-back issue
            end else begin
              state        <= ST_IDLE;
              mem_read_out <= 1'b0;
            end
          end
        end

        ST_DISCARD: begin
          // The stale response ends the old request even if another redirect
          // arrives in the same cycle. That redirect has already updated
          // fetch_pc, so IDLE then fetches from the latest target.
          if (mem_valid_in) begin
            state        <= ST_IDLE;
            mem_read_out <= 1'b0;
          end
        end

        default: begin
          state        <= ST_IDLE;
          mem_read_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
